multisim_apb_arbiter: RTL and testbench



---
 rtl/multisim_apb_arb_pkg.sv | 45 ++++
 rtl/multisim_rr_arbiter.sv | 24 ++
 rtl/multisim_apb_arbiter.sv | 126 ++++++++++++
 tb/tb_multisim_apb_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_apb_arb_pkg.sv
// Shared types and the round-robin pick helper for the multisim APB arbiter family.
package multisim_apb_arb_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_req_s;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_s;

  // First valid index strictly after last, wrapping at n; returns last if nothing is valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] vld,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned cand;
    bit          found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (last + k) % n;
      if (k <= n && !found && vld[cand[3:0]]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multisim_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant and index from the valid vector and last owner.
module multisim_rr_arbiter
  import multisim_apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] vld_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [MAX_REQ-1:0] vld_ext;

  always_comb begin
    vld_ext                = '0;
    vld_ext[NUM_REQ-1:0]   = vld_i;
    gnt_idx_o              = IDX_W'(rr_pick(vld_ext, 32'(last_i), NUM_REQ));
    gnt_o                  = '0;
    if (|vld_i) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/multisim_apb_arbiter.sv
// Round-robin arbiter sharing one APB manager port between NUM_REQ valid/ready requesters,
// with a held response per transfer and a sticky ACCESS-phase timeout flag.
module multisim_apb_arbiter
  import multisim_apb_arb_pkg::*;
#(
  parameter type         apb_req_t      = apb_req_s,
  parameter type         apb_resp_t     = apb_resp_s,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic      [NUM_REQ-1:0]  i_req_vld,
  output logic      [NUM_REQ-1:0]  o_req_rdy,
  input  apb_req_t  [NUM_REQ-1:0]  i_req,
  output logic      [NUM_REQ-1:0]  o_rsp_vld,
  input  logic      [NUM_REQ-1:0]  i_rsp_rdy,
  output apb_resp_t                o_rsp,
  output apb_req_t                 o_apb_m_req,
  output logic                     o_apb_m_psel,
  output logic                     o_apb_m_penable,
  input  logic                     i_apb_m_pready,
  input  apb_resp_t                i_apb_m_resp,
  output logic      [IDX_W-1:0]    o_grant_idx,
  output logic                     o_timeout
);

  localparam int unsigned      CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  apb_req_t           req_q, req_d;
  apb_resp_t          resp_q, resp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;

  multisim_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .vld_i     (i_req_vld),
    .last_i    (last_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      req_q     <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    req_d           = req_q;
    resp_d          = resp_q;
    cnt_d           = cnt_q;
    timeout_d       = timeout_q;
    o_req_rdy       = '0;
    o_rsp_vld       = '0;
    o_apb_m_psel    = 1'b0;
    o_apb_m_penable = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|i_req_vld) begin
          o_req_rdy = pick_gnt;
          req_d     = i_req[pick_idx];
          grant_d   = pick_idx;
          state_d   = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        o_apb_m_psel = 1'b1;
        cnt_d        = '0;
        state_d      = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        o_apb_m_psel    = 1'b1;
        o_apb_m_penable = 1'b1;
        if (i_apb_m_pready) begin
          resp_d  = i_apb_m_resp;
          state_d = ARB_RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q != CNT_LIMIT) begin
          // Keep waiting: APB has no abort, the flag only reports the stall.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LIMIT) timeout_d = 1'b1;
        end
      end
      ARB_RESP: begin
        o_rsp_vld[grant_q] = 1'b1;
        if (i_rsp_rdy[grant_q]) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign o_apb_m_req = req_q;
  assign o_rsp       = resp_q;
  assign o_grant_idx = grant_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_multisim_apb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a round-robin model.
module tb_multisim_apb_arbiter;
  import multisim_apb_arb_pkg::*;

  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld, rsp_rdy;
  apb_req_s [N-1:0] req;
  apb_resp_s       apb_resp;
  logic            pready;

  logic [N-1:0] req_rdy, rsp_vld, req_rdy_b, rsp_vld_b;
  apb_resp_s    rsp, rsp_b;
  apb_req_s     apb_req, apb_req_b;
  logic         psel, penable, psel_b, penable_b, timeout, timeout_b;
  logic [1:0]   grant_idx, grant_b;

  int checks = 0;
  int errors = 0;
  int m_last;

  always #5 clk = ~clk;

  multisim_apb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req(req),
    .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp(rsp), .o_apb_m_req(apb_req),
    .o_apb_m_psel(psel), .o_apb_m_penable(penable), .i_apb_m_pready(pready),
    .i_apb_m_resp(apb_resp), .o_grant_idx(grant_idx), .o_timeout(timeout)
  );

  multisim_apb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy_b), .i_req(req),
    .o_rsp_vld(rsp_vld_b), .i_rsp_rdy(rsp_rdy), .o_rsp(rsp_b), .o_apb_m_req(apb_req_b),
    .o_apb_m_psel(psel_b), .o_apb_m_penable(penable_b), .i_apb_m_pready(pready),
    .i_apb_m_resp(apb_resp), .o_grant_idx(grant_b), .o_timeout(timeout_b)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; rsp_rdy = '1; pready = 1'b0;
    next_cycle();
    rst = 1'b0;
    m_last = N - 1;
  endtask

  // Round-robin rule: first valid requester after the last owner, wrapping.
  function automatic int model_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int idx);
    logic [N-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic apb_req_s rand_req();
    apb_req_s r;
    r.paddr = $urandom; r.pwrite = 1'($urandom); r.pwdata = $urandom;
    r.pstrb = 4'($urandom); r.pprot = 3'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; rsp_rdy = '1; pready = 1'b0; apb_resp = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    m_last = N - 1;
    @(negedge clk);
    checks++;
    if (req_rdy !== '0 || rsp_vld !== '0) begin
      errors++; $display("FAIL reset_handshake: rdy=%b vld=%b want 000/000", req_rdy, rsp_vld);
    end
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      errors++; $display("FAIL reset_apb: psel=%b penable=%b want 0/0", psel, penable);
    end
    checks++;
    if (timeout !== 1'b0 || timeout_b !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b/%b want 0/0", timeout, timeout_b);
    end
    next_cycle();
  endtask

  task automatic test_single();
    apb_req_s  r;
    apb_resp_s s;
    r = '{paddr: 32'h10, pwrite: 1'b1, pwdata: 32'hDEADBEEF, pstrb: 4'hF, pprot: 3'h0};
    s = '{prdata: 32'hCAFE0001, pslverr: 1'b0};
    req[0] = r; req_vld = 3'b001; pready = 1'b1; rsp_rdy = '1; apb_resp = s;
    @(negedge clk);
    checks++;
    if (req_rdy !== 3'b001) begin
      errors++; $display("FAIL single_rdy: got %b want 001", req_rdy);
    end
    next_cycle();
    req_vld = '0;
    @(negedge clk);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || apb_req !== r || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_setup: psel=%b pen=%b req=%h gnt=%0d want 1/0/%h/0",
               psel, penable, apb_req, grant_idx, r);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || apb_req !== r) begin
      errors++; $display("FAIL single_access: psel=%b pen=%b req=%h", psel, penable, apb_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_vld !== 3'b001 || rsp !== s || psel !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: vld=%b rsp=%h psel=%b want 001/%h/0", rsp_vld, rsp, psel, s);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_vld !== '0 || psel !== 1'b0 || req_rdy !== '0) begin
      errors++; $display("FAIL single_idle: vld=%b psel=%b rdy=%b", rsp_vld, psel, req_rdy);
    end
    m_last = 0;
    next_cycle();
  endtask

  task automatic test_contention();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) req[i] = rand_req();
    req_vld = '1; rsp_rdy = '1; pready = 1'b1; apb_resp = '{prdata: 32'h1111, pslverr: 1'b0};
    for (int t = 0; t < 6; t++) begin
      exp = t % N;
      @(negedge clk);
      checks++;
      if (req_rdy !== onehot(exp)) begin
        errors++; $display("FAIL contention_rdy[%0d]: got %b want %b", t, req_rdy, onehot(exp));
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (grant_idx !== 2'(exp) || psel !== 1'b1 || penable !== 1'b0 || apb_req !== req[exp]) begin
        errors++;
        $display("FAIL contention_setup[%0d]: gnt=%0d psel=%b pen=%b want gnt %0d",
                 t, grant_idx, psel, penable, exp);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (penable !== 1'b1 || req_rdy !== '0) begin
        errors++; $display("FAIL contention_access[%0d]: pen=%b rdy=%b", t, penable, req_rdy);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (rsp_vld !== onehot(exp)) begin
        errors++; $display("FAIL contention_resp[%0d]: got %b want %b", t, rsp_vld, onehot(exp));
      end
      next_cycle();
      m_last = exp;
    end
    req_vld = '0;
  endtask

  task automatic test_wait_states();
    apb_req_s  r;
    apb_resp_s s;
    r = rand_req();
    s = '{prdata: 32'hA5A5A5A5, pslverr: 1'b1};
    req[1] = r; req_vld = 3'b010; pready = 1'b0; apb_resp = '0;
    @(negedge clk);
    checks++;
    if (req_rdy !== 3'b010) begin
      errors++; $display("FAIL wait_rdy: got %b want 010", req_rdy);
    end
    next_cycle();
    req_vld = '0;
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        pready = 1'b1; apb_resp = s;
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || apb_req !== r || timeout !== 1'b0) begin
        errors++;
        $display("FAIL wait_access[%0d]: psel=%b pen=%b req=%h tmo=%b want 1/1/%h/0",
                 k, psel, penable, apb_req, timeout, r);
      end
      next_cycle();
    end
    pready = 1'b0; apb_resp = '0;
    @(negedge clk);
    checks++;
    if (rsp_vld !== 3'b010 || rsp !== s) begin
      errors++; $display("FAIL wait_resp: vld=%b rsp=%h want 010/%h", rsp_vld, rsp, s);
    end
    next_cycle();
    m_last = 1;
  endtask

  task automatic test_timeout();
    do_reset();
    req[2] = rand_req(); req_vld = 3'b100; pready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_rdy !== 3'b100) begin
      errors++; $display("FAIL timeout_rdy: got %b want 100", req_rdy);
    end
    next_cycle();
    req_vld = '0;
    next_cycle();
    for (int k = 1; k <= 11; k++) begin
      pready = (k == 11);
      @(negedge clk);
      checks++;
      if (timeout_b !== 1'(k >= 5) || timeout !== 1'(k >= 9)) begin
        errors++;
        $display("FAIL timeout_flag[%0d]: t4=%b t8=%b want %b/%b",
                 k, timeout_b, timeout, 1'(k >= 5), 1'(k >= 9));
      end
      next_cycle();
    end
    pready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_vld_b !== 3'b100 || timeout_b !== 1'b1) begin
      errors++; $display("FAIL timeout_complete: vld=%b tmo=%b want 100/1", rsp_vld_b, timeout_b);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (timeout_b !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b/%b want 1/1", timeout_b, timeout);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (timeout_b !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b/%b want 0/0", timeout_b, timeout);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    apb_resp_s s;
    s = '{prdata: 32'h5A5A0001, pslverr: 1'b0};
    req[0] = rand_req(); req[1] = rand_req();
    req_vld = 3'b010; pready = 1'b1; rsp_rdy = 3'b101;
    @(negedge clk);
    checks++;
    if (req_rdy !== 3'b010) begin
      errors++; $display("FAIL bp_rdy: got %b want 010", req_rdy);
    end
    next_cycle();
    req_vld = 3'b011;
    next_cycle();
    apb_resp = s;
    next_cycle();
    apb_resp = '{prdata: 32'hFFFF0000, pslverr: 1'b1};
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_vld !== 3'b010 || rsp !== s || req_rdy !== '0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: vld=%b rsp=%h rdy=%b want 010/%h/000",
                 k, rsp_vld, rsp, req_rdy, s);
      end
      next_cycle();
    end
    rsp_rdy = '1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (req_rdy !== 3'b001) begin
      errors++; $display("FAIL bp_next_grant: got %b want 001", req_rdy);
    end
    next_cycle();
    req_vld = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_vld !== 3'b001) begin
      errors++; $display("FAIL bp_req0_resp: got %b want 001", rsp_vld);
    end
    next_cycle();
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    req[1] = rand_req(); req_vld = 3'b010; pready = 1'b0; rsp_rdy = '1;
    next_cycle();
    req_vld = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; pready = 1'b1; req_vld = 3'b011; m_last = N - 1;
    @(negedge clk);
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_vld !== '0) begin
      errors++; $display("FAIL rstmid_abandon: psel=%b pen=%b vld=%b", psel, penable, rsp_vld);
    end
    checks++;
    if (req_rdy !== 3'b001) begin
      errors++; $display("FAIL rstmid_grant: got %b want 001", req_rdy);
    end
    next_cycle();
    req_vld = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_vld !== 3'b001) begin
      errors++; $display("FAIL rstmid_resp: got %b want 001", rsp_vld);
    end
    next_cycle();
    m_last = 0;
  endtask

  task automatic test_random();
    int        exp, wait_n, stall_n;
    apb_req_s  er;
    apb_resp_s es;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) req[i] = rand_req();
      req_vld = 3'($urandom_range(0, 7));
      exp = model_pick(req_vld, m_last);
      @(negedge clk);
      checks++;
      if (exp < 0) begin
        if (req_rdy !== '0) begin
          errors++; $display("FAIL rand_idle[%0d]: got %b want 000", it, req_rdy);
        end
        next_cycle();
      end else begin
        if (req_rdy !== onehot(exp)) begin
          errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", it, req_rdy, onehot(exp));
        end
        er = req[exp];
        next_cycle();
        req_vld = 3'($urandom_range(0, 7)); req[exp] = rand_req();
        @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || apb_req !== er || grant_idx !== 2'(exp)) begin
          errors++;
          $display("FAIL rand_setup[%0d]: psel=%b pen=%b req=%h gnt=%0d want req %h gnt %0d",
                   it, psel, penable, apb_req, grant_idx, er, exp);
        end
        next_cycle();
        wait_n = $urandom_range(0, 3);
        for (int w = 0; w <= wait_n; w++) begin
          pready = (w == wait_n);
          apb_resp = '{prdata: $urandom, pslverr: 1'($urandom)};
          es = apb_resp;
          @(negedge clk);
          checks++;
          if (psel !== 1'b1 || penable !== 1'b1 || apb_req !== er || req_rdy !== '0) begin
            errors++;
            $display("FAIL rand_access[%0d]: psel=%b pen=%b req=%h rdy=%b want req %h",
                     it, psel, penable, apb_req, req_rdy, er);
          end
          next_cycle();
        end
        pready = 1'b0;
        stall_n = $urandom_range(0, 2);
        for (int s = 0; s <= stall_n; s++) begin
          rsp_rdy = 3'($urandom_range(0, 7));
          rsp_rdy[exp] = (s == stall_n);
          apb_resp = '{prdata: $urandom, pslverr: 1'($urandom)};
          @(negedge clk);
          checks++;
          if (rsp_vld !== onehot(exp) || rsp !== es) begin
            errors++;
            $display("FAIL rand_resp[%0d]: vld=%b rsp=%h want %b/%h",
                     it, rsp_vld, rsp, onehot(exp), es);
          end
          next_cycle();
        end
        m_last = exp;
      end
    end
    req_vld = '0; rsp_rdy = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
